// File: rtl/mac_pe_v2_if.sv
// mac_pe_v2_if: control, operand and neighbour-forwarding bundle for one PE.
// master drives controls/operands and reads results; slave is the PE side.
interface mac_pe_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LANES      = 4
);
    logic                          clr;
    logic                          load_weight;
    logic                          swap_weight;
    logic                          signed_mode;
    logic                          act_valid_in;
    logic [LANES*DATA_WIDTH-1:0]   act_in;
    logic [LANES*DATA_WIDTH-1:0]   weight_in;
    logic [ACC_WIDTH-1:0]          psum_in;
    logic                          act_valid_out;
    logic [LANES*DATA_WIDTH-1:0]   act_out;
    logic [LANES*DATA_WIDTH-1:0]   weight_out;
    logic [ACC_WIDTH-1:0]          psum_out;
    logic                          psum_valid_out;
    logic                          sat_flag;

    modport master (
        output clr, load_weight, swap_weight, signed_mode,
        output act_valid_in, act_in, weight_in, psum_in,
        input  act_valid_out, act_out, weight_out,
        input  psum_out, psum_valid_out, sat_flag
    );

    modport slave (
        input  clr, load_weight, swap_weight, signed_mode,
        input  act_valid_in, act_in, weight_in, psum_in,
        output act_valid_out, act_out, weight_out,
        output psum_out, psum_valid_out, sat_flag
    );
endinterface

// File: rtl/mac_pe_v2.sv
// mac_pe_v2: weight-stationary MAC PE with shadow/active weight banks,
// runtime signed/unsigned operands and an optional multiply stage.
// Ports: clk, rst_n (async active-low), bus (mac_pe_v2_if.slave):
//   in : clr, load_weight, swap_weight, signed_mode, act_valid_in,
//        act_in, weight_in, psum_in
//   out: act_valid_out, act_out, weight_out, psum_out,
//        psum_valid_out, sat_flag
// Macro SATURATE_EN: saturating accumulate with sticky sat_flag;
// when undefined the add wraps and sat_flag is tied 0.
module mac_pe_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LANES      = 4,
    parameter int MULT_PIPE  = 1
) (
    input logic        clk,
    input logic        rst_n,
    mac_pe_v2_if.slave bus
);
    localparam int VW = LANES * DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    if (LANES < 1) begin : g_bad_lanes
        $error("mac_pe_v2: LANES must be >= 1");
    end
    if (ACC_WIDTH < PW + $clog2(LANES) + 1) begin : g_bad_acc
        $error("mac_pe_v2: ACC_WIDTH too narrow for the dot product");
    end

    // Extend both operands to PW, multiply, extend the product to ACC.
    // The PW-bit truncated product is exact for either signedness.
    function automatic logic [ACC_WIDTH-1:0] lane_prod(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] w,
        input logic                  sgn
    );
        logic [PW-1:0] ae;
        logic [PW-1:0] we;
        logic [PW-1:0] p;
        ae = sgn ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}
                 : {{DATA_WIDTH{1'b0}}, a};
        we = sgn ? {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w}
                 : {{DATA_WIDTH{1'b0}}, w};
        p  = ae * we;
        return sgn ? {{(ACC_WIDTH-PW){p[PW-1]}}, p}
                   : {{(ACC_WIDTH-PW){1'b0}}, p};
    endfunction

    logic [VW-1:0] shadow_q, shadow_d;
    logic [VW-1:0] active_q, active_d;
    logic [VW-1:0] weight_out_q;
    logic [VW-1:0] act_out_q;
    logic          act_valid_out_q;

    always_comb begin
        shadow_d = bus.load_weight ? bus.weight_in : shadow_q;
        active_d = bus.swap_weight ? shadow_q : active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q        <= '0;
            active_q        <= '0;
            weight_out_q    <= '0;
            act_out_q       <= '0;
            act_valid_out_q <= 1'b0;
        end else begin
            shadow_q        <= shadow_d;
            active_q        <= active_d;
            weight_out_q    <= shadow_q;
            act_out_q       <= bus.act_in;
            act_valid_out_q <= bus.act_valid_in;
        end
    end

    logic [ACC_WIDTH-1:0] dot_d;

    always_comb begin
        dot_d = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_d = dot_d + lane_prod(
                bus.act_in[i*DATA_WIDTH +: DATA_WIDTH],
                active_q[i*DATA_WIDTH +: DATA_WIDTH],
                bus.signed_mode);
        end
    end

    // Stage S1: registered when MULT_PIPE, otherwise plain wires.
    logic                 s1_valid;
    logic                 s1_signed;
    logic [ACC_WIDTH-1:0] s1_dot;
    logic [ACC_WIDTH-1:0] s1_psum;

    if (MULT_PIPE != 0) begin : g_pipe
        logic                 s1_valid_q;
        logic                 s1_signed_q;
        logic [ACC_WIDTH-1:0] s1_dot_q;
        logic [ACC_WIDTH-1:0] s1_psum_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q  <= 1'b0;
                s1_signed_q <= 1'b0;
                s1_dot_q    <= '0;
                s1_psum_q   <= '0;
            end else begin
                // clr flushes any product that would be in flight
                s1_valid_q  <= bus.act_valid_in & ~bus.clr;
                s1_signed_q <= bus.signed_mode;
                s1_dot_q    <= dot_d;
                s1_psum_q   <= bus.psum_in;
            end
        end

        assign s1_valid  = s1_valid_q;
        assign s1_signed = s1_signed_q;
        assign s1_dot    = s1_dot_q;
        assign s1_psum   = s1_psum_q;
    end else begin : g_comb
        assign s1_valid  = bus.act_valid_in;
        assign s1_signed = bus.signed_mode;
        assign s1_dot    = dot_d;
        assign s1_psum   = bus.psum_in;
    end

    logic [ACC_WIDTH-1:0] psum_q, psum_d;
    logic                 psum_valid_q, psum_valid_d;

`ifdef SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic             sat_q, sat_d;
    logic [ACC_WIDTH:0] sum_ext;

    always_comb begin
        psum_d       = s1_psum;
        psum_valid_d = 1'b0;
        sat_d        = sat_q;
        sum_ext      = {1'b0, s1_psum} + {1'b0, s1_dot};
        if (bus.clr) begin
            psum_d = '0;
            sat_d  = 1'b0;
        end else if (s1_valid) begin
            psum_valid_d = 1'b1;
            psum_d       = sum_ext[ACC_WIDTH-1:0];
            if (s1_signed) begin
                // same-sign operands giving an opposite-sign result
                if (s1_psum[ACC_WIDTH-1] == s1_dot[ACC_WIDTH-1] &&
                    sum_ext[ACC_WIDTH-1] != s1_psum[ACC_WIDTH-1]) begin
                    psum_d = s1_psum[ACC_WIDTH-1] ? SMIN : SMAX;
                    sat_d  = 1'b1;
                end
            end else if (sum_ext[ACC_WIDTH]) begin
                psum_d = '1;
                sat_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign bus.sat_flag = sat_q;
`else
    // signedness only matters to the clamp logic
    logic unused_s1_signed;
    assign unused_s1_signed = s1_signed;

    always_comb begin
        psum_d       = s1_psum;
        psum_valid_d = 1'b0;
        if (bus.clr) begin
            psum_d = '0;
        end else if (s1_valid) begin
            psum_valid_d = 1'b1;
            psum_d       = s1_psum + s1_dot;
        end
    end

    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
        end
    end

    assign bus.psum_out       = psum_q;
    assign bus.psum_valid_out = psum_valid_q;
    assign bus.act_out        = act_out_q;
    assign bus.act_valid_out  = act_valid_out_q;
    assign bus.weight_out     = weight_out_q;
endmodule

// File: tb/tb_mac_pe_v2.sv
// tb_mac_pe_v2: directed self-checking bench for mac_pe_v2
// (DATA_WIDTH=8, ACC_WIDTH=32, LANES=4, MULT_PIPE=1).
module tb_mac_pe_v2;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mac_pe_v2_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LANES(4)) bus ();

    mac_pe_v2 #(
        .DATA_WIDTH(8), .ACC_WIDTH(32), .LANES(4), .MULT_PIPE(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.clr          = 1'b0;
        bus.load_weight  = 1'b0;
        bus.swap_weight  = 1'b0;
        bus.act_valid_in = 1'b0;
        bus.act_in       = '0;
        bus.weight_in    = '0;
        bus.psum_in      = '0;
    endtask

    // load shadow, then swap into active (two edges)
    task automatic set_active(input logic [31:0] w);
        bus.load_weight = 1'b1;
        bus.weight_in   = w;
        cyc();
        bus.load_weight = 1'b0;
        bus.swap_weight = 1'b1;
        cyc();
        bus.swap_weight = 1'b0;
    endtask

    // one valid activation, then wait for the two-edge result
    task automatic mac_once(input logic [31:0] a, input logic [31:0] p,
                            input logic sgn);
        bus.signed_mode  = sgn;
        bus.act_valid_in = 1'b1;
        bus.act_in       = a;
        bus.psum_in      = p;
        cyc();
        bus.act_valid_in = 1'b0;
        bus.act_in       = '0;
        bus.psum_in      = '0;
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // reset with busy inputs
        rst_n            = 1'b0;
        bus.clr          = 1'b0;
        bus.load_weight  = 1'b1;
        bus.swap_weight  = 1'b1;
        bus.signed_mode  = 1'b1;
        bus.act_valid_in = 1'b1;
        bus.act_in       = 32'hA5A5A5A5;
        bus.weight_in    = 32'h5A5A5A5A;
        bus.psum_in      = 32'h12345678;
        #12;
        chk("rst_psum", bus.psum_out, 0);
        chk("rst_pvalid", bus.psum_valid_out, 0);
        chk("rst_act", bus.act_out, 0);
        chk("rst_avalid", bus.act_valid_out, 0);
        chk("rst_wout", bus.weight_out, 0);
        chk("rst_sat", bus.sat_flag, 0);
        idle();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_psum", bus.psum_out, 0);
        chk("idle_pvalid", bus.psum_valid_out, 0);
        chk("idle_wout", bus.weight_out, 0);

        // basic dot product, signed
        bus.signed_mode = 1'b1;
        set_active(32'h04030201);
        chk("basic_wout", bus.weight_out, 32'h04030201);
        bus.act_valid_in = 1'b1;
        bus.act_in       = 32'h01010101;
        bus.psum_in      = 32'd10;
        cyc();
        chk("basic_lat1_valid", bus.psum_valid_out, 0);
        chk("basic_act_out", bus.act_out, 32'h01010101);
        chk("basic_act_vout", bus.act_valid_out, 1);
        bus.act_valid_in = 1'b0;
        bus.act_in       = '0;
        bus.psum_in      = '0;
        cyc();
        chk("basic_psum", bus.psum_out, 32'd20);
        chk("basic_valid", bus.psum_valid_out, 1);
        chk("basic_avout_drop", bus.act_valid_out, 0);
        cyc();
        chk("basic_valid_drop", bus.psum_valid_out, 0);

        // signedness: 0xFF * 0x80
        set_active(32'h000000FF);
        mac_once(32'h00000080, 32'd0, 1'b1);
        chk("signed_prod", bus.psum_out, 32'd128);
        mac_once(32'h00000080, 32'd0, 1'b0);
        chk("unsigned_prod", bus.psum_out, 32'd32640);
        bus.signed_mode = 1'b1;

        // double buffer: same-edge load+swap keeps the old shadow active
        set_active(32'h01010101);
        bus.load_weight = 1'b1;
        bus.swap_weight = 1'b1;
        bus.weight_in   = 32'h05050505;
        cyc();
        bus.load_weight = 1'b0;
        bus.swap_weight = 1'b0;
        bus.weight_in   = '0;
        chk("dbuf_wout_old", bus.weight_out, 32'h01010101);
        bus.act_valid_in = 1'b1;
        bus.act_in       = 32'h01010101;
        cyc();
        chk("dbuf_wout_new", bus.weight_out, 32'h05050505);
        bus.act_valid_in = 1'b0;
        bus.act_in       = '0;
        cyc();
        chk("dbuf_old_sum", bus.psum_out, 32'd4);
        bus.swap_weight = 1'b1;
        cyc();
        bus.swap_weight = 1'b0;
        mac_once(32'h01010101, 32'd7, 1'b1);
        chk("dbuf_new_sum", bus.psum_out, 32'd27);

        // swap on the same edge as a valid act: that product uses old bank
        bus.load_weight = 1'b1;
        bus.weight_in   = 32'h02020202;
        cyc();
        bus.load_weight  = 1'b0;
        bus.swap_weight  = 1'b1;
        bus.act_valid_in = 1'b1;
        bus.act_in       = 32'h01010101;
        cyc();
        bus.swap_weight = 1'b0;
        cyc();
        chk("swap_inflight_old", bus.psum_out, 32'd20);
        bus.act_valid_in = 1'b0;
        bus.act_in       = '0;
        cyc();
        chk("swap_next_new", bus.psum_out, 32'd8);

        // signed overflow
        set_active(32'h08080808);
        mac_once(32'h01010101, 32'h7FFFFFF0, 1'b1);
`ifdef SATURATE_EN
        chk("ovf_s_psum", bus.psum_out, 32'h7FFFFFFF);
        chk("ovf_s_flag", bus.sat_flag, 1);
`else
        chk("ovf_s_psum", bus.psum_out, 32'h80000010);
        chk("ovf_s_flag", bus.sat_flag, 0);
`endif
        cyc();
`ifdef SATURATE_EN
        chk("ovf_sticky", bus.sat_flag, 1);
`else
        chk("ovf_sticky", bus.sat_flag, 0);
`endif
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        chk("ovf_clr_flag", bus.sat_flag, 0);
        chk("ovf_clr_psum", bus.psum_out, 0);

        // unsigned overflow
        mac_once(32'h01010101, 32'hFFFFFFF0, 1'b0);
`ifdef SATURATE_EN
        chk("ovf_u_psum", bus.psum_out, 32'hFFFFFFFF);
        chk("ovf_u_flag", bus.sat_flag, 1);
`else
        chk("ovf_u_psum", bus.psum_out, 32'h00000010);
        chk("ovf_u_flag", bus.sat_flag, 0);
`endif
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        bus.signed_mode = 1'b1;

        // clr mid-stream
        bus.act_valid_in = 1'b1;
        bus.act_in       = 32'h01010101;
        bus.psum_in      = 32'd0;
        cyc();
        cyc();
        cyc();
        chk("stream_psum", bus.psum_out, 32'd32);
        chk("stream_valid", bus.psum_valid_out, 1);
        bus.clr = 1'b1;
        cyc();
        chk("clr_psum", bus.psum_out, 0);
        chk("clr_valid", bus.psum_valid_out, 0);
        chk("clr_avout", bus.act_valid_out, 1);
        bus.clr    = 1'b0;
        bus.act_in = 32'h02020202;
        cyc();
        chk("clr_flushed", bus.psum_valid_out, 0);
        bus.act_valid_in = 1'b0;
        bus.act_in       = '0;
        cyc();
        chk("post_clr_psum", bus.psum_out, 32'd64);
        chk("post_clr_valid", bus.psum_valid_out, 1);
        cyc();
        chk("post_clr_drop", bus.psum_valid_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_pe_v2.md
Name: mac_pe_v2

Overview:
Next-generation weight-stationary processing element for the GEMM systolic array. Computes a LANES-wide dot product per cycle, adds it to the incoming partial sum, and forwards activations, weights and partial sums to its neighbours. Adds three things: double-buffered (shadow/active) weights so the next tile loads during compute, a runtime signed/unsigned mode, and an optional multiply pipeline stage. Instantiated as an R x C grid by the array wrapper.

Parameters:
DATA_WIDTH, 8, width of each activation/weight element
ACC_WIDTH, 32, partial-sum width; must be >= 2*DATA_WIDTH + $clog2(LANES) + 1 (elaboration-time check)
LANES, 4, activation/weight pairs per cycle; must be >= 1
MULT_PIPE, 1, 0 = combinational product into accumulate; 1 = one register stage after the dot-product sum

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  clear accumulator and flush the pipeline
load_weight  in  1  write weight_in into the shadow weight bank
swap_weight  in  1  copy the shadow bank into the active bank
signed_mode  in  1  1 = operands signed two's complement, 0 = unsigned
act_valid_in  in  1  act_in is valid this cycle
act_in  in  LANES*DATA_WIDTH  packed activations, lane 0 in the LSBs
weight_in  in  LANES*DATA_WIDTH  packed weights for the shadow load
psum_in  in  ACC_WIDTH  partial sum from the neighbour
act_valid_out  out  1  registered act_valid_in
act_out  out  LANES*DATA_WIDTH  registered act_in
weight_out  out  LANES*DATA_WIDTH  registered shadow bank, for daisy-chain loading
psum_out  out  ACC_WIDTH  accumulator register
psum_valid_out  out  1  psum_out holds a newly computed sum
sat_flag  out  1  sticky saturation indicator; tied 0 without SATURATE_EN

Behaviour:
- Reset (async): every register is 0, including the shadow bank, active bank, pipeline stage and all outputs.
- Shadow bank: when load_weight=1, shadow <= weight_in.
- weight_out <= shadow every cycle, so a downstream PE sees the shadow value one cycle later.
- Active bank: when swap_weight=1, active <= shadow (the pre-edge value).
- load_weight and swap_weight together: active gets the old shadow value; shadow gets weight_in.
- Forwarding: act_out <= act_in and act_valid_out <= act_valid_in every cycle. Latency is 1 regardless of MULT_PIPE and clr.
- Dot product: p_i = act_i * active_i, with both operands sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to 2*DATA_WIDTH.
- The lane sum of all p_i is extended to ACC_WIDTH using the same signedness.
- MULT_PIPE=1: dot sum, act_valid_in, signed_mode and psum_in are registered together into stage S1. MULT_PIPE=0: stage S1 is wires.
- Accumulate stage (registered psum_out / psum_valid_out), priority order:
  - clr=1: psum_out <= 0 and psum_valid_out <= 0; the S1 valid is also cleared, so no in-flight product survives.
  - else S1 valid=1: psum_out <= psum_S1 + dot_S1 and psum_valid_out <= 1.
  - else: psum_out <= psum_S1 (pass-through) and psum_valid_out <= 0.
- Latency: act_valid_in at edge t gives psum_out / psum_valid_out at edge t+1+MULT_PIPE.
- Without saturation, the add wraps modulo 2^ACC_WIDTH.
- A swap takes effect on products computed from the edge after the swap. Products already in S1 use the previous active bank.

Optional Feature:
Macro SATURATE_EN.
- Defined: the add saturates. With signed_mode=1 it clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. With signed_mode=0, psum is treated as unsigned and clamps to 2^ACC_WIDTH-1.
- Defined: any clamp sets sat_flag; it stays 1 until clr or reset.
- Undefined: wrap-around arithmetic, and sat_flag is constant 0.

Test Plan:
1. Reset: drive nonzero inputs with rst_n=0 -> all outputs 0. Deassert with no stimulus -> outputs stay 0.
2. Basic: load {1,2,3,4}, swap, act {1,1,1,1} valid, psum_in=10, signed, MULT_PIPE=1 -> psum_out=20 with psum_valid_out=1 exactly two edges after act_valid_in; psum_valid_out=0 the following cycle.
3. Signedness: lane0 weight 0xFF, act 0x80, other lanes 0 -> signed_mode=1 gives 128; signed_mode=0 gives 32640.
4. Double buffer: active {1,1,1,1}; same-cycle load {5,5,5,5} and swap; then act {1,1,1,1} -> first sum uses the old shadow. A second swap gives 20 + psum_in. weight_out shows {5,5,5,5} one edge after the load.
5. Overflow, signed: psum_in=0x7FFFFFF0, dot=0x20.
   - Without SATURATE_EN -> psum_out=0x80000010, sat_flag=0.
   - With SATURATE_EN -> psum_out=0x7FFFFFFF, sat_flag=1; sat_flag returns to 0 after clr.
6. clr mid-stream: valid acts every cycle, MULT_PIPE=1, assert clr one cycle -> next edge psum_out=0 and psum_valid_out=0; the next valid output is from an activation issued after clr.
